flp_relu: RTL and testbench



---
 rtl/flp_relu.sv | 60 ++++++
 tb/tb_flp_relu.sv | 120 ++++++++++++
 2 files changed

// File: rtl/flp_relu.sv
// flp_relu: floating-point ReLU / Leaky-ReLU with one registered output stage
module flp_relu #(
    parameter int EWIDTH = 8,
    parameter int SWIDTH = 23
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic [EWIDTH+SWIDTH:0]   i_v,
    input  logic                     i_l,
    input  logic [EWIDTH-2:0]        i_e,
    output logic [EWIDTH+SWIDTH:0]   o_r
);
    localparam int W = 1 + EWIDTH + SWIDTH;

    logic                     s;
    logic [EWIDTH-1:0]        x;
    logic [SWIDTH-1:0]        f;
    logic                     x_max, x_zero, is_nan;
    logic signed [EWIDTH+1:0] y;
    logic                     y_under, y_over;
    logic [W-1:0]             r_d, r_q;

    assign s      = i_v[W-1];
    assign x      = i_v[W-2 -: EWIDTH];
    assign f      = i_v[SWIDTH-1:0];
    assign x_max  = &x;
    assign x_zero = ~|x;
    assign is_nan = x_max & (|f);
    // exponent shift in two extra bits so both underflow and overflow are visible
    assign y       = $signed({2'b00, x}) + $signed({{3{i_e[EWIDTH-2]}}, i_e});
    assign y_under = y[EWIDTH+1] | ~|y;
    assign y_over  = ~y[EWIDTH+1] & (y[EWIDTH] | &y[EWIDTH-1:0]);

    // negative non-NaN inputs are clamped (ReLU) or exponent-scaled (leaky); all else passes
    always_comb begin
        r_d = i_v;
        if (s && !is_nan) begin
            if (!i_l)
                r_d = '0;
            else if (x_max)
                r_d = i_v;
            else if (x_zero || y_under)
                r_d = {1'b1, {(W-1){1'b0}}};
            else if (y_over)
                r_d = {1'b1, {EWIDTH{1'b1}}, {SWIDTH{1'b0}}};
            else
                r_d = {1'b1, y[EWIDTH-1:0], f};
        end
    end

    // output register, cleared by synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!nrst)
            r_q <= '0;
        else
            r_q <= r_d;
    end

    assign o_r = r_q;
endmodule

// File: tb/tb_flp_relu.sv
// tb_flp_relu: randomized and directed checks of flp_relu against a value-level model
module tb_flp_relu;
    logic        clk = 1'b0;
    logic        nrst;
    logic [31:0] i_v;
    logic        i_l;
    logic [6:0]  i_e;
    logic [31:0] o_r;
    int          n_vec = 0;
    int          n_err = 0;

    flp_relu #(.EWIDTH(8), .SWIDTH(23)) dut (
        .clk(clk), .nrst(nrst), .i_v(i_v), .i_l(i_l), .i_e(i_e), .o_r(o_r)
    );

    always #5 clk = ~clk;

    // reference: decode fields as integers and apply the activation rules directly
    function automatic logic [31:0] ref_relu(logic [31:0] v, logic l, logic [6:0] e);
        int ex, fr, sh, y;
        ex = int'(v[30:23]);
        fr = int'(v[22:0]);
        sh = int'($signed(e));
        if (ex == 255 && fr != 0) return v;
        if (!v[31]) return v;
        if (!l) return 32'h0000_0000;
        if (ex == 255) return v;
        if (ex == 0) return 32'h8000_0000;
        y = ex + sh;
        if (y <= 0) return 32'h8000_0000;
        if (y >= 255) return 32'hff80_0000;
        return {1'b1, 8'(y), v[22:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // called at a negedge: drive inputs, then check the registered result one cycle later
    task automatic step(input string tag, input logic [31:0] v, input logic l,
                        input logic [6:0] e, input logic [31:0] exp);
        i_v = v;
        i_l = l;
        i_e = e;
        @(negedge clk);
        chk(tag, o_r, exp);
    endtask

    function automatic logic [31:0] rnd_val();
        logic [7:0]  x;
        logic [22:0] f;
        case ($urandom_range(0, 4))
            0:       x = 8'd0;
            1:       x = 8'd255;
            2:       x = 8'($urandom_range(1, 8));
            3:       x = 8'($urandom_range(247, 254));
            default: x = 8'($urandom_range(0, 255));
        endcase
        f = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
        return {1'($urandom), x, f};
    endfunction

    initial begin
        logic [31:0] v;
        logic        l;
        logic [6:0]  e;
        nrst = 1'b0;
        i_v  = 32'h4180_0000;
        i_l  = 1'b1;
        i_e  = 7'h7c;
        repeat (2) @(negedge clk);
        chk("reset", o_r, 32'h0);
        nrst = 1'b1;

        step("relu_p0",   32'h0000_0000, 1'b0, 7'h7c, 32'h0000_0000);
        step("relu_n0",   32'h8000_0000, 1'b0, 7'h7c, 32'h0000_0000);
        step("relu_pos",  32'h4180_0000, 1'b0, 7'h7c, 32'h4180_0000);
        step("relu_neg",  32'hc180_0000, 1'b0, 7'h7c, 32'h0000_0000);
        step("relu_pinf", 32'h7f80_0000, 1'b0, 7'h7c, 32'h7f80_0000);
        step("relu_ninf", 32'hff80_0000, 1'b0, 7'h7c, 32'h0000_0000);
        step("relu_pnan", 32'h7fff_ffff, 1'b0, 7'h7c, 32'h7fff_ffff);
        step("relu_nnan", 32'hffff_ffff, 1'b0, 7'h7c, 32'hffff_ffff);
        step("lk_neg",    32'hc180_0000, 1'b1, 7'h7c, 32'hbf80_0000);
        step("lk_pos",    32'h4180_0000, 1'b1, 7'h7c, 32'h4180_0000);
        step("lk_p0",     32'h0000_0000, 1'b1, 7'h7c, 32'h0000_0000);
        step("lk_n0",     32'h8000_0000, 1'b1, 7'h7c, 32'h8000_0000);
        step("lk_ninf",   32'hff80_0000, 1'b1, 7'h7c, 32'hff80_0000);
        step("lk_pinf",   32'h7f80_0000, 1'b1, 7'h7c, 32'h7f80_0000);
        step("lk_nnan",   32'hffff_ffff, 1'b1, 7'h7c, 32'hffff_ffff);
        step("lk_pnan",   32'h7fff_ffff, 1'b1, 7'h7c, 32'h7fff_ffff);
        step("lk_under",  32'h8180_0000, 1'b1, 7'h7c, 32'h8000_0000);
        step("lk_over",   32'hff00_0000, 1'b1, 7'h03, 32'hff80_0000);
        step("lk_denorm", 32'h8000_0001, 1'b1, 7'h7c, 32'h8000_0000);
        step("lk_edge1",  32'h8280_0000, 1'b1, 7'h7c, 32'h8080_0000);
        step("lk_edge254",32'hfe80_0000, 1'b1, 7'h01, 32'hff00_0000);

        for (int i = 0; i < 300; i++) begin
            v = rnd_val();
            l = 1'($urandom);
            e = 7'($urandom);
            if (i == 150) begin
                nrst = 1'b0;
                i_v  = v;
                i_l  = l;
                i_e  = e;
                @(negedge clk);
                chk("mid_reset", o_r, 32'h0);
                nrst = 1'b1;
            end
            step("rand", v, l, e, ref_relu(v, l, e));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
